// File: rtl/yauart_pkg.sv
// -----------------------------------------------------------------------------
// yauart_pkg
// Shared definitions for the YAUART receive path (and the TX core, which
// reuses yauart_baud_tick):
//   - rx_state_e      : receiver FSM states
//   - OVERSAMPLE_DEF  : default oversample ticks per bit
//   - DATA_BITS / BIT_IDX_W / LAST_BIT_IDX : frame data-bit counting
//   - majority3()     : 2-of-3 vote used for bit decisions
//   - xor_reduce8()   : even parity of a data byte
// -----------------------------------------------------------------------------
package yauart_pkg;

   localparam int OVERSAMPLE_DEF = 16;

   localparam int DATA_BITS = 8;
   localparam int BIT_IDX_W = $clog2(DATA_BITS);
   localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = BIT_IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4,
      RX_BREAK  = 3'd5
   } rx_state_e;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic xor_reduce8(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/yauart_baud_tick.sv
// -----------------------------------------------------------------------------
// yauart_baud_tick
// Oversample tick generator. A counter runs 0..div_i and emits a one-clock
// tick on the wrap; div_i = 0 gives a tick every clock. clr_i holds the
// counter at 0 (no tick) so a frame always starts on a fresh tick phase.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   clr_i   synchronous clear / hold at 0
//   div_i   clocks per tick minus 1
//   tick_o  one-cycle tick pulse
// -----------------------------------------------------------------------------
module yauart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic             wrap_s;

   assign wrap_s = (cnt_q == div_i);
   assign tick_o = wrap_s & ~clr_i;

   // Next count: clear, wrap, or increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (wrap_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Divider counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/yauart_rx_core.sv
// -----------------------------------------------------------------------------
// yauart_rx_core
// UART receiver: synchronizes rxd_i, deframes 8N1 LSB-first frames (8E1/8O1
// when YAUART_RX_PARITY_EN is defined) and presents each byte in a
// valid/ready holding register.
// Optional feature macro: YAUART_RX_PARITY_EN (adds the parity bit state and
// parity_err_o; without it parity_odd_i is ignored and parity_err_o is 0).
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   rx_en_i             receiver enable (0 aborts any frame in progress)
//   baud_div_i          clocks per oversample tick minus 1
//   parity_odd_i        1 = odd, 0 = even parity
//   rxd_i               asynchronous serial line, idle high
//   rx_data_o/valid_o   holding register; rx_ready_i consumes
//   frame_err_o         pulse: stop bit sampled low
//   overrun_err_o       pulse: byte completed while holding register full
//   parity_err_o        pulse: parity mismatch
//   busy_o              receiver FSM not idle
// -----------------------------------------------------------------------------
module yauart_rx_core
   import yauart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DIV_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rx_en_i,
   input  logic [DIV_W-1:0] baud_div_i,
   input  logic             parity_odd_i,
   input  logic             rxd_i,
   output logic [7:0]       rx_data_o,
   output logic             rx_valid_o,
   input  logic             rx_ready_i,
   output logic             frame_err_o,
   output logic             overrun_err_o,
   output logic             parity_err_o,
   output logic             busy_o
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   // Three vote samples centred on the middle of the bit.
   localparam logic [OS_W-1:0] SMP_A   = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0] SMP_B   = OS_W'(OVERSAMPLE / 2);
   localparam logic [OS_W-1:0] SMP_C   = OS_W'(OVERSAMPLE / 2 + 1);

   // Line synchronizer and edge history.
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic rxd_prev_q, rxd_prev_d;

   // Framing state.
   rx_state_e             state_q, state_d;
   logic [OS_W-1:0]       os_q, os_d;
   logic [BIT_IDX_W-1:0]  bit_q, bit_d;
   logic [1:0]            samp_q, samp_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;

   // Holding register and error pulses.
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       frame_err_q, frame_err_d;
   logic       overrun_q, overrun_d;

   logic rxd_s;
   logic fall_s;
   logic tick_s;
   logic tick_clr_s;
   logic maj_s;
   logic decide_s;
   logic bit_end_s;
   logic deliver_s;

`ifdef YAUART_RX_PARITY_EN
   logic parity_err_q, parity_err_d;
`else
   logic unused_parity_odd_s;
   assign unused_parity_odd_s = parity_odd_i;
`endif

   assign rxd_s  = sync2_q;
   assign fall_s = rxd_prev_q & ~sync2_q;

   // The tick phase restarts at every frame; BREAK only watches the line.
   assign tick_clr_s = (state_q == RX_IDLE) || (state_q == RX_BREAK);

   yauart_baud_tick #(
      .DIV_W (DIV_W)
   ) u_baud_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (tick_clr_s),
      .div_i  (baud_div_i),
      .tick_o (tick_s)
   );

   // The third vote is the live synchronized line at the decision tick.
   assign maj_s     = majority3(samp_q[0], samp_q[1], rxd_s);
   assign decide_s  = tick_s & (os_q == SMP_C);
   assign bit_end_s = tick_s & (os_q == OS_LAST);

   // Synchronizer shift path.
   always_comb begin
      sync1_d    = rxd_i;
      sync2_d    = sync1_q;
      rxd_prev_d = sync2_q;
   end

   // Receiver FSM: next state, oversample/bit counters, sampling and pulses.
   always_comb begin
      state_d     = state_q;
      os_d        = os_q;
      bit_d       = bit_q;
      samp_d      = samp_q;
      shift_d     = shift_q;
      deliver_s   = 1'b0;
      frame_err_d = 1'b0;
`ifdef YAUART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif

      if (tick_s) begin
         if (os_q == SMP_A) begin
            samp_d[0] = rxd_s;
         end else if (os_q == SMP_B) begin
            samp_d[1] = rxd_s;
         end else begin
            samp_d = samp_q;
         end
         if (bit_end_s) begin
            os_d = '0;
         end else begin
            os_d = os_q + OS_ONE;
         end
      end else begin
         os_d = os_q;
      end

      if (!rx_en_i) begin
         // Disable drops any partial frame silently.
         state_d = RX_IDLE;
      end else begin
         case (state_q)
            RX_IDLE: begin
               os_d  = '0;
               bit_d = '0;
               if (fall_s) begin
                  state_d = RX_START;
               end else begin
                  state_d = RX_IDLE;
               end
            end
            RX_START: begin
               if (decide_s && maj_s) begin
                  // Start bit not low at its centre: treat as a glitch.
                  state_d = RX_IDLE;
               end else if (bit_end_s) begin
                  state_d = RX_DATA;
                  bit_d   = '0;
               end else begin
                  state_d = RX_START;
               end
            end
            RX_DATA: begin
               if (decide_s) begin
                  shift_d = {maj_s, shift_q[DATA_BITS-1:1]};
               end else begin
                  shift_d = shift_q;
               end
               if (bit_end_s) begin
                  if (bit_q == LAST_BIT_IDX) begin
`ifdef YAUART_RX_PARITY_EN
                     state_d = RX_PARITY;
`else
                     state_d = RX_STOP;
`endif
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  bit_d = bit_q;
               end
            end
`ifdef YAUART_RX_PARITY_EN
            RX_PARITY: begin
               if (decide_s) begin
                  parity_err_d = maj_s ^ xor_reduce8(shift_q) ^ parity_odd_i;
               end else begin
                  parity_err_d = 1'b0;
               end
               if (bit_end_s) begin
                  state_d = RX_STOP;
               end else begin
                  state_d = RX_PARITY;
               end
            end
`endif
            RX_STOP: begin
               if (decide_s) begin
                  if (maj_s) begin
                     // Leave at the stop-bit centre so the next start edge is seen.
                     deliver_s = 1'b1;
                     state_d   = RX_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = RX_BREAK;
                  end
               end else begin
                  state_d = RX_STOP;
               end
            end
            RX_BREAK: begin
               if (rxd_s) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d = RX_BREAK;
               end
            end
            default: begin
               state_d = RX_IDLE;
            end
         endcase
      end
   end

   // Holding register: load when empty or drained this cycle, else overrun.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (valid_q && rx_ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
      if (deliver_s) begin
         if (!valid_q || rx_ready_i) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else begin
         data_d = data_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         rxd_prev_q  <= 1'b1;
         state_q     <= RX_IDLE;
         os_q        <= '0;
         bit_q       <= '0;
         samp_q      <= 2'b00;
         shift_q     <= '0;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         rxd_prev_q  <= rxd_prev_d;
         state_q     <= state_d;
         os_q        <= os_d;
         bit_q       <= bit_d;
         samp_q      <= samp_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef YAUART_RX_PARITY_EN
   // Parity error pulse register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end
   assign parity_err_o = parity_err_q;
`else
   assign parity_err_o = 1'b0;
`endif

   assign rx_data_o     = data_q;
   assign rx_valid_o    = valid_q;
   assign frame_err_o   = frame_err_q;
   assign overrun_err_o = overrun_q;
   assign busy_o        = (state_q != RX_IDLE);

endmodule

// File: tb/tb_yauart_rx_core.sv
module tb_yauart_rx_core;

   localparam int DIV      = 3;
   localparam int BIT_CLKS = 16 * (DIV + 1);
`ifdef YAUART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   // Stop bit spans [STOP_BASE, STOP_BASE+BIT_CLKS) clocks after the start edge;
   // the byte must appear after the stop centre region begins and before it ends.
   localparam int STOP_BASE = (9 + PAR_BITS) * BIT_CLKS;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_en;
   logic [15:0] baud_div;
   logic        parity_odd;
   logic        rxd;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        frame_err;
   logic        overrun_err;
   logic        parity_err;
   logic        busy;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int start_cyc = 0;
   int rise_cyc = 0;
   int rise_cnt = 0;
   int frame_cnt = 0;
   int overrun_cnt = 0;
   int parity_cnt = 0;
   int busy_rise_cnt = 0;
   logic busy_at_rise = 1'b0;
   logic valid_prev = 1'b0;
   logic busy_prev = 1'b0;
   logic last_par = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   yauart_rx_core #(.OVERSAMPLE(16), .DIV_W(16)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .rx_en_i       (rx_en),
      .baud_div_i    (baud_div),
      .parity_odd_i  (parity_odd),
      .rxd_i         (rxd),
      .rx_data_o     (rx_data),
      .rx_valid_o    (rx_valid),
      .rx_ready_i    (rx_ready),
      .frame_err_o   (frame_err),
      .overrun_err_o (overrun_err),
      .parity_err_o  (parity_err),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor on the falling edge: collect handshaken bytes and count events.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
         if (rx_valid && !valid_prev) begin
            rise_cnt     <= rise_cnt + 1;
            rise_cyc     <= cyc;
            busy_at_rise <= busy;
         end
         if (frame_err)   frame_cnt   <= frame_cnt + 1;
         if (overrun_err) overrun_cnt <= overrun_cnt + 1;
         if (parity_err)  parity_cnt  <= parity_cnt + 1;
         if (busy && !busy_prev) busy_rise_cnt <= busy_rise_cnt + 1;
      end
      valid_prev <= rx_valid;
      busy_prev  <= busy;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return (^d) ^ parity_odd;
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic par_bit,
                             input logic stop_bit, input int stop_clks);
      last_par  = par_bit;
      rxd       = 1'b0;
      start_cyc = cyc;
      step(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         step(BIT_CLKS);
      end
`ifdef YAUART_RX_PARITY_EN
      rxd = par_bit;
      step(BIT_CLKS);
`endif
      rxd = stop_bit;
      step(stop_clks);
      rxd = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; rxd = 1'b1; rx_en = 1'b1; rx_ready = 1'b0;
      parity_odd = 1'b0; baud_div = 16'(DIV);
      step(3);
      tests_run++;
      if ({rx_data, rx_valid, frame_err, overrun_err, parity_err, busy} !== 13'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {rx_data, rx_valid, frame_err, overrun_err, parity_err, busy});
      end
      rst = 1'b0;
      step(5);
      tests_run++;
      if ({rx_valid, busy} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_release_idle: got %b expected 00", {rx_valid, busy});
      end
   endtask

   task automatic test_basic;
      int f0, o0, p0, r0, lat;
      logic [7:0] g, e;
      rx_ready = 1'b1;
      f0 = frame_cnt; o0 = overrun_cnt; p0 = parity_cnt; r0 = rise_cnt;
      step(20);
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, good_par(8'hA5), 1'b1, BIT_CLKS);
      step(4);
      tests_run++;
      if (got_q.size() == 0) begin
         tests_failed++;
         $display("FAIL basic_data: got no byte expected a5");
         void'(exp_q.pop_front());
      end else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         if (g !== e) begin
            tests_failed++;
            $display("FAIL basic_data: got %h expected %h", g, e);
         end
      end
      lat = rise_cyc - start_cyc;
      tests_run++;
      if (rise_cnt - r0 != 1 || lat < STOP_BASE + BIT_CLKS / 4 || lat > STOP_BASE + BIT_CLKS) begin
         tests_failed++;
         $display("FAIL basic_latency: got rises=%0d latency=%0d expected 1 rise in [%0d,%0d]",
                  rise_cnt - r0, lat, STOP_BASE + BIT_CLKS / 4, STOP_BASE + BIT_CLKS);
      end
      tests_run++;
      if (busy_at_rise !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_idle_at_valid: got busy=%b expected 0", busy_at_rise);
      end
      tests_run++;
      if ((frame_cnt - f0) + (overrun_cnt - o0) + (parity_cnt - p0) != 0) begin
         tests_failed++;
         $display("FAIL basic_no_err: got %0d error pulses expected 0",
                  (frame_cnt - f0) + (overrun_cnt - o0) + (parity_cnt - p0));
      end
      tests_run++;
      if (rx_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_valid_drop: got %b expected 0", rx_valid);
      end
   endtask

   task automatic test_back_to_back;
      int o0;
      logic [7:0] g, e;
      rx_ready = 1'b0;
      o0 = overrun_cnt;
      step(20);
      send_frame(8'h3C, good_par(8'h3C), 1'b1, BIT_CLKS);
      send_frame(8'hC3, good_par(8'hC3), 1'b1, BIT_CLKS);
      step(4);
      tests_run++;
      if ({rx_valid, rx_data} !== {1'b1, 8'h3C}) begin
         tests_failed++;
         $display("FAIL b2b_hold: got valid=%b data=%h expected valid=1 data=3c", rx_valid, rx_data);
      end
      tests_run++;
      if (overrun_cnt - o0 != 1) begin
         tests_failed++;
         $display("FAIL b2b_overrun: got %0d pulses expected 1", overrun_cnt - o0);
      end
      exp_q.push_back(8'h3C);
      rx_ready = 1'b1;
      step(1);
      tests_run++;
      if (rx_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_handshake_clear: got %b expected 0", rx_valid);
      end
      step(3);
      tests_run++;
      if (got_q.size() != 1) begin
         tests_failed++;
         $display("FAIL b2b_one_handshake: got %0d bytes expected 1", got_q.size());
         while (exp_q.size() > 0) void'(exp_q.pop_front());
         while (got_q.size() > 0) void'(got_q.pop_front());
      end else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         if (g !== e) begin
            tests_failed++;
            $display("FAIL b2b_data: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_glitch;
      int r0, b0, errs0;
      r0 = rise_cnt; b0 = busy_rise_cnt; errs0 = frame_cnt + overrun_cnt + parity_cnt;
      step(20);
      rxd = 1'b0;
      step(3);
      rxd = 1'b1;
      step(10);
      tests_run++;
      if (busy !== 1'b1 || busy_rise_cnt - b0 != 1) begin
         tests_failed++;
         $display("FAIL glitch_start: got busy=%b rises=%0d expected 1 and 1", busy, busy_rise_cnt - b0);
      end
      step(2 * BIT_CLKS);
      tests_run++;
      if (busy !== 1'b0 || rise_cnt != r0 || frame_cnt + overrun_cnt + parity_cnt != errs0) begin
         tests_failed++;
         $display("FAIL glitch_reject: got busy=%b valid_rises=%0d errs=%0d expected 0 0 0",
                  busy, rise_cnt - r0, frame_cnt + overrun_cnt + parity_cnt - errs0);
      end
   endtask

   task automatic test_break;
      int f0, r0;
      logic [7:0] g, e;
      rx_ready = 1'b1;
      f0 = frame_cnt; r0 = rise_cnt;
      step(20);
      send_frame(8'h55, good_par(8'h55), 1'b0, 3 * BIT_CLKS);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL break_busy_low: got %b expected 1", busy);
      end
      tests_run++;
      if (frame_cnt - f0 != 1 || rise_cnt != r0) begin
         tests_failed++;
         $display("FAIL break_frame_err: got pulses=%0d valid_rises=%0d expected 1 0",
                  frame_cnt - f0, rise_cnt - r0);
      end
      step(5);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL break_release: got busy=%b expected 0", busy);
      end
      step(20);
      exp_q.push_back(8'h12);
      send_frame(8'h12, good_par(8'h12), 1'b1, BIT_CLKS);
      step(4);
      tests_run++;
      if (got_q.size() == 0) begin
         tests_failed++;
         $display("FAIL break_next_byte: got no byte expected 12");
         void'(exp_q.pop_front());
      end else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         if (g !== e) begin
            tests_failed++;
            $display("FAIL break_next_byte: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_parity;
      int p0;
      logic [7:0] g, e;
      rx_ready = 1'b1;
`ifdef YAUART_RX_PARITY_EN
      // 0x07 has three ones: even parity expects 1, odd parity expects 0.
      logic [2:0] odd_tab = 3'b100;
      logic [2:0] bit_tab = 3'b010;
      logic [2:0] err_tab = 3'b001;
      for (int k = 0; k < 3; k++) begin
         parity_odd = odd_tab[k];
         p0 = parity_cnt;
         step(20);
         exp_q.push_back(8'h07);
         send_frame(8'h07, bit_tab[k], 1'b1, BIT_CLKS);
         step(4);
         tests_run++;
         if (parity_cnt - p0 != int'(err_tab[k])) begin
            tests_failed++;
            $display("FAIL parity_err_%0d: got %0d pulses expected %0d", k, parity_cnt - p0, err_tab[k]);
         end
         tests_run++;
         if (got_q.size() == 0) begin
            tests_failed++;
            $display("FAIL parity_data_%0d: got no byte expected 07", k);
            void'(exp_q.pop_front());
         end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin
               tests_failed++;
               $display("FAIL parity_data_%0d: got %h expected %h", k, g, e);
            end
         end
      end
`else
      parity_odd = 1'b1;
      p0 = parity_cnt;
      step(20);
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b0, 1'b1, BIT_CLKS);
      step(4);
      tests_run++;
      if (parity_cnt != 0 || parity_cnt != p0) begin
         tests_failed++;
         $display("FAIL parity_tied_off: got %0d pulses expected 0", parity_cnt);
      end
      tests_run++;
      if (got_q.size() == 0) begin
         tests_failed++;
         $display("FAIL parity_off_data: got no byte expected 07");
         void'(exp_q.pop_front());
      end else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         if (g !== e) begin
            tests_failed++;
            $display("FAIL parity_off_data: got %h expected %h", g, e);
         end
      end
`endif
      parity_odd = 1'b0;
   endtask

   task automatic test_disable_reset;
      int r0, errs0;
      logic [7:0] pat = 8'h5A;
      rx_ready = 1'b1;
      r0 = rise_cnt; errs0 = frame_cnt + overrun_cnt + parity_cnt;
      step(20);
      rxd = 1'b0;
      step(BIT_CLKS);
      for (int i = 0; i < 3; i++) begin
         rxd = pat[i];
         step(BIT_CLKS);
      end
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL disable_busy_before: got %b expected 1", busy);
      end
      rx_en = 1'b0;
      step(1);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL disable_idle_next: got %b expected 0", busy);
      end
      for (int i = 3; i < 8; i++) begin
         rxd = pat[i];
         step(BIT_CLKS);
      end
      rxd = 1'b1;
      step(2 * BIT_CLKS);
      rx_en = 1'b1;
      step(10);
      tests_run++;
      if (rise_cnt != r0 || frame_cnt + overrun_cnt + parity_cnt != errs0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL disable_silent: got rises=%0d errs=%0d busy=%b expected 0 0 0",
                  rise_cnt - r0, frame_cnt + overrun_cnt + parity_cnt - errs0, busy);
      end
      // Leave a byte pending, then reset in the middle of the next frame.
      rx_ready = 1'b0;
      step(20);
      send_frame(8'h81, good_par(8'h81), 1'b1, BIT_CLKS);
      step(4);
      tests_run++;
      if ({rx_valid, rx_data} !== {1'b1, 8'h81}) begin
         tests_failed++;
         $display("FAIL reset_pending: got valid=%b data=%h expected valid=1 data=81", rx_valid, rx_data);
      end
      step(20);
      rxd = 1'b0;
      step(3 * BIT_CLKS);
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({rx_data, rx_valid, frame_err, overrun_err, parity_err, busy} !== 13'h0) begin
         tests_failed++;
         $display("FAIL reset_async: got %h expected 0",
                  {rx_data, rx_valid, frame_err, overrun_err, parity_err, busy});
      end
      rxd = 1'b1;
      step(3);
      rst = 1'b0;
      r0 = rise_cnt;
      step(12 * BIT_CLKS);
      tests_run++;
      if (rise_cnt != r0 || rx_valid !== 1'b0 || got_q.size() != 0) begin
         tests_failed++;
         $display("FAIL reset_no_byte: got rises=%0d valid=%b bytes=%0d expected 0 0 0",
                  rise_cnt - r0, rx_valid, got_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_glitch();
      test_break();
      test_parity();
      test_disable_reset();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
